// File: rtl/rom_burst_reader.sv
// rom_burst_reader: elaboration-filled read-only word table with a burst
// engine that streams LANES consecutive words per beat over valid/ready.
// Optional feature macro: ROM_PARITY_EN adds a per-lane even-parity output.
module rom_burst_reader #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LANES     = 8,
    parameter int          INIT_BASE = 0,
    parameter int          INIT_STEP = 1,
    parameter int unsigned BEAT_W    = 8,
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OW       = WIDTH * LANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     start_addr,
    input  logic [BEAT_W-1:0] beats,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_data,
    output logic              out_last,
    output logic              done
`ifdef ROM_PARITY_EN
    ,
    output logic [LANES-1:0]  out_parity
`endif
);

    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned ACC_W = AW + LW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                valid_q;
    logic                last_q;
    logic                done_q;
    logic [OW-1:0]       data_q;
    logic [BEAT_W-1:0]   remain_q;
    logic [AW-1:0]       next_base_q;

    logic [AW-1:0]       load_base_d;
    logic [AW-1:0]       next_base_d;
    logic [OW-1:0]       data_d;
    logic [ACC_W-1:0]    lane_acc;
    logic [AW-1:0]       lane_idx;

    // Constant table: mem[i] = (INIT_BASE + i*INIT_STEP) mod 2**WIDTH
    logic [WIDTH-1:0] rom [DEPTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = WIDTH'(INIT_BASE + i * INIT_STEP);
    end

    // Beat to load next: first beat from start_addr, later beats from the running base
    always_comb begin
        load_base_d = (state_q == IDLE) ? start_addr : next_base_q;
        next_base_d = AW'((ACC_W'(load_base_d) + ACC_W'(LANES)) % ACC_W'(DEPTH));
        data_d      = '0;
        lane_acc    = '0;
        lane_idx    = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_acc = ACC_W'(load_base_d) + ACC_W'(j);
            lane_idx = AW'(lane_acc % ACC_W'(DEPTH));
            data_d[j*WIDTH +: WIDTH] = rom[lane_idx];
        end
    end

`ifdef ROM_PARITY_EN
    logic [LANES-1:0] parity_d;
    logic [LANES-1:0] parity_q;

    // Even-parity bit per lane of the beat being loaded
    always_comb begin
        parity_d = '0;
        for (int j = 0; j < LANES; j++) begin
            parity_d[j] = ^data_d[j*WIDTH +: WIDTH];
        end
    end

    // Parity register follows the data register exactly (loads and stalls)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= '0;
        end else if ((state_q == IDLE && start && beats != '0) ||
                     (state_q == RUN && out_ready && !last_q)) begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

    // Burst FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            remain_q    <= '0;
            next_base_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (beats == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            busy_q      <= 1'b1;
                            valid_q     <= 1'b1;
                            data_q      <= data_d;
                            last_q      <= (beats == BEAT_W'(1));
                            remain_q    <= beats - BEAT_W'(1);
                            next_base_q <= next_base_d;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            data_q      <= data_d;
                            last_q      <= (remain_q == BEAT_W'(1));
                            remain_q    <= remain_q - BEAT_W'(1);
                            next_base_q <= next_base_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-of-beats model.
module tb_rom_burst_reader;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned LANES     = 8;
    localparam int          INIT_BASE = 0;
    localparam int          INIT_STEP = 1;
    localparam int unsigned BEAT_W    = 8;
    localparam int unsigned AW        = 4;
    localparam int unsigned OW        = WIDTH * LANES;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     start_addr = '0;
    logic [BEAT_W-1:0] beats = '0;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              out_valid;
    logic [OW-1:0]     out_data;
    logic              out_last;
    logic              done;
`ifdef ROM_PARITY_EN
    logic [LANES-1:0]  out_parity;
`endif

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    rom_burst_reader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES),
        .INIT_BASE(INIT_BASE), .INIT_STEP(INIT_STEP), .BEAT_W(BEAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .beats(beats), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .done(done)
`ifdef ROM_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    // Table word at absolute address i
    function automatic logic [WIDTH-1:0] mem(int i);
        return WIDTH'(INIT_BASE + (i % DEPTH) * INIT_STEP);
    endfunction

    // Beat k of a burst starting at sa
    function automatic logic [OW-1:0] beat_of(int sa, int k);
        logic [OW-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) r[j*WIDTH +: WIDTH] = mem(sa + k * LANES + j);
        return r;
    endfunction

    function automatic logic [LANES-1:0] parity_of(logic [OW-1:0] d);
        logic [LANES-1:0] p;
        p = '0;
        for (int j = 0; j < LANES; j++) p[j] = ^d[j*WIDTH +: WIDTH];
        return p;
    endfunction

    task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a burst is just the list of its beats; done follows the final pop
    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;
    beat_t q[$];
    bit    m_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (q.size() > 0) begin
                if (out_ready) begin
                    if (q[0].l) m_done = 1'b1;
                    void'(q.pop_front());
                end
            end else if (start) begin
                if (beats == '0) m_done = 1'b1;
                else begin
                    for (int k = 0; k < int'(beats); k++) begin
                        beat_t b;
                        b.d = beat_of(int'(start_addr), k);
                        b.l = (k == int'(beats) - 1);
                        q.push_back(b);
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            check("m_busy",  OW'(busy),      OW'(q.size() > 0));
            check("m_valid", OW'(out_valid), OW'(q.size() > 0));
            check("m_done",  OW'(done),      OW'(m_done));
            if (q.size() > 0) begin
                check("m_data", out_data, q[0].d);
                check("m_last", OW'(out_last), OW'(q[0].l));
`ifdef ROM_PARITY_EN
                check("m_parity", OW'(out_parity), OW'(parity_of(q[0].d)));
`endif
            end else begin
                check("m_last_idle", OW'(out_last), '0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Pin the model against hand-computed beats
        check("model_beat0", beat_of(0, 0), 32'h76543210);
        check("model_beat1", beat_of(0, 1), 32'hFEDCBA98);
        check("model_wrap",  beat_of(12, 0), 32'h3210FEDC);
        check("model_par",   OW'(parity_of(32'h76543210)), OW'(8'b1001_0110));

        // Reset state
        step();
        armed = 1'b1;
        step();
        check("rst_valid", OW'(out_valid), '0);
        check("rst_busy",  OW'(busy), '0);
        check("rst_data",  out_data, '0);
        check("rst_last",  OW'(out_last), '0);
        check("rst_done",  OW'(done), '0);
`ifdef ROM_PARITY_EN
        check("rst_parity", OW'(out_parity), '0);
`endif
        rst_n = 1'b1;

        // Two-beat burst, ready high
        out_ready = 1'b1;
        start = 1'b1; start_addr = 4'd0; beats = 8'd2;
        step();
        start = 1'b0;
        check("t1_b0_data", out_data, 32'h76543210);
        check("t1_b0_last", OW'(out_last), '0);
        check("t1_b0_valid", OW'(out_valid), OW'(1));
        step();
        check("t1_b1_data", out_data, 32'hFEDCBA98);
        check("t1_b1_last", OW'(out_last), OW'(1));
        step();
        check("t1_done", OW'(done), OW'(1));
        check("t1_busy", OW'(busy), '0);
        step();
        check("t1_done_pulse", OW'(done), '0);

        // Wrap-around
        start = 1'b1; start_addr = 4'd12; beats = 8'd1;
        step();
        start = 1'b0;
        check("t2_data", out_data, 32'h3210FEDC);
        check("t2_last", OW'(out_last), OW'(1));
        step();
        check("t2_done", OW'(done), OW'(1));

        // Stall
        out_ready = 1'b0;
        start = 1'b1; start_addr = 4'd0; beats = 8'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_data", out_data, 32'h76543210);
            check("t3_hold_valid", OW'(out_valid), OW'(1));
            check("t3_no_done", OW'(done), '0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("t3_b1_data", out_data, 32'hFEDCBA98);
        step();
        check("t3_done", OW'(done), OW'(1));

        // Empty burst
        start = 1'b1; beats = 8'd0;
        step();
        start = 1'b0;
        check("t4_empty_done", OW'(done), OW'(1));
        check("t4_empty_valid", OW'(out_valid), '0);
        step();
        check("t4_empty_after", OW'(out_valid), '0);

        // Restart during RUN is ignored
        start = 1'b1; start_addr = 4'd4; beats = 8'd3;
        step();
        start_addr = 4'd9; beats = 8'd1;
        check("t4_run_b0", out_data, 32'hBA987654);
        step();
        check("t4_run_b1", out_data, 32'h3210FEDC);
        start = 1'b0;
        step();
        check("t4_run_b2", out_data, 32'hBA987654);
        check("t4_run_last", OW'(out_last), OW'(1));
        step();
        check("t4_run_done", OW'(done), OW'(1));

        // Reset mid-burst
        start = 1'b1; start_addr = 4'd0; beats = 8'd4;
        step();
        start = 1'b0;
        rst_n = 1'b0;
        step();
        check("t5_valid", OW'(out_valid), '0);
        check("t5_data", out_data, '0);
        check("t5_busy", OW'(busy), '0);
        check("t5_done", OW'(done), '0);
        rst_n = 1'b1;
        step();
        check("t5_no_done", OW'(done), '0);
        start = 1'b1; start_addr = 4'd0; beats = 8'd1;
        step();
        start = 1'b0;
        check("t5_restart", out_data, 32'h76543210);
`ifdef ROM_PARITY_EN
        check("t6_parity", OW'(out_parity), OW'(8'b1001_0110));
`endif
        step();

        // Long burst wrapping the table several times
        start = 1'b1; start_addr = 4'd5; beats = 8'd6;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            out_ready  = ($urandom_range(0, 9) < 7);
            start      = ($urandom_range(0, 9) < 3);
            start_addr = AW'($urandom_range(0, DEPTH - 1));
            beats      = BEAT_W'($urandom_range(0, 6));
            rst_n      = ($urandom_range(0, 99) >= 2);
            step();
        end

        // Drain with a bounded wait
        rst_n = 1'b1; start = 1'b0; out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (busy && n < 100) begin
                step();
                n++;
            end
            check("drain_idle", OW'(busy), '0);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
